// File: rtl/lamp_timer_ctrl.sv
// -----------------------------------------------------------------------------
// lamp_timer_ctrl
//
// Timed staircase-lamp controller. Three raw switch inputs are synchronised
// and debounced; every settled toggle of any switch (after the first accepted
// level of that switch) produces a single lamp event. An event turns the lamp
// on for ON_SEC seconds, and a new event restarts the hold. The remaining
// seconds are shown on one active-low 7-segment digit.
//
// Optional feature macro: LAMP_WARN_EN
//   When defined, F blinks during the last second of the hold: high for the
//   first half of the second, low for the second half.
//
// Parameters
//   TICK_DIV : clk cycles per one-second tick (>= 2)
//   DB_CYC   : stable cycles required to accept a switch level (>= 1)
//   ON_SEC   : hold time in seconds (1..9)
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   S1, S2, S3 : raw switch levels, asynchronous to clk
//   LED[6:0]   : segments {g,f,e,d,c,b,a}, active-low
//   F          : lamp drive, active-high
// -----------------------------------------------------------------------------
`default_nettype none

module lamp_timer_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DB_CYC   = 1_000_000,
  parameter int ON_SEC   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  output logic [6:0] LED,
  output logic       F
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int STAB_W = $clog2(DB_CYC + 1);

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DB_CYC);
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0]        CNT_LOAD = 4'(ON_SEC);
`ifdef LAMP_WARN_EN
  localparam logic [PRE_W-1:0]  PRE_HALF = PRE_W'(TICK_DIV / 2);
`endif

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } state_t;

  // Active-low 7-segment decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [2:0]        raw;
  logic [2:0]        sw_p0;
  logic [2:0]        sw_p1;
  logic [2:0]        db;
  logic [2:0]        armed;
  logic [2:0]        chg;
  logic [STAB_W-1:0] stab [3];
  logic              evt;

  state_t            state;
  state_t            state_nx;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nx;
  logic [PRE_W-1:0]  pre;
  logic [PRE_W-1:0]  pre_nx;
  logic              tick;
  logic [6:0]        led_q;

  assign raw = {S3, S2, S1};

  // ---- stage p0/p1: two-flop synchroniser, then per-switch debounce ----
  // Before a switch is armed, its debounced value simply follows the
  // synchronised level and the counter measures how long that level has been
  // steady; once steady for DB_CYC cycles the switch is armed silently. After
  // arming, the counter measures how long the synchronised level has
  // disagreed with the debounced one, and acceptance raises chg for a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
      db    <= '0;
      armed <= '0;
      chg   <= '0;
      for (int i = 0; i < 3; i++) begin
        stab[i] <= '0;
      end
    end else begin
      sw_p0 <= raw;
      sw_p1 <= sw_p0;
      chg   <= '0;
      for (int i = 0; i < 3; i++) begin
        if (!armed[i]) begin
          if (sw_p1[i] != db[i]) begin
            db[i]   <= sw_p1[i];
            stab[i] <= '0;
          end else if (stab[i] == STAB_MAX) begin
            armed[i] <= 1'b1;
            stab[i]  <= '0;
          end else begin
            stab[i] <= stab[i] + STAB_W'(1);
          end
        end else begin
          if (sw_p1[i] == db[i]) begin
            stab[i] <= '0;
          end else if (stab[i] == STAB_MAX) begin
            db[i]   <= sw_p1[i];
            chg[i]  <= 1'b1;
            stab[i] <= '0;
          end else begin
            stab[i] <= stab[i] + STAB_W'(1);
          end
        end
      end
    end
  end

  // Simultaneous changes on several switches collapse into one event.
  assign evt  = |chg;
  assign tick = (pre == PRE_MAX);

  // ---- stage p2: lamp FSM, seconds counter and prescaler ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      cnt   <= 4'd0;
      pre   <= '0;
      led_q <= 7'b1000000;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pre   <= pre_nx;
      led_q <= seg7(cnt_nx);
    end
  end

  // An event always wins over the expiring tick, so a retrigger on the last
  // tick keeps the lamp on with a full reload.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pre_nx   = '0;
    case (state)
      OFF: begin
        cnt_nx = 4'd0;
        if (evt) begin
          state_nx = ON;
          cnt_nx   = CNT_LOAD;
        end
      end
      ON: begin
        if (evt) begin
          cnt_nx = CNT_LOAD;
        end else if (tick) begin
          if (cnt > 4'd1) begin
            cnt_nx = cnt - 4'd1;
          end else begin
            state_nx = OFF;
            cnt_nx   = 4'd0;
          end
        end else begin
          pre_nx = pre + PRE_W'(1);
        end
      end
      default: begin
        state_nx = OFF;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  assign LED = led_q;

`ifdef LAMP_WARN_EN
  // Warning blink in the final second: lamp on only in the first half.
  assign F = (state == ON) && !((cnt == 4'd1) && (pre >= PRE_HALF));
`else
  assign F = (state == ON);
`endif

endmodule

`default_nettype wire

// File: tb/tb_lamp_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lamp_timer_ctrl
//
// Self-checking bench for lamp_timer_ctrl with TICK_DIV=10, DB_CYC=4,
// ON_SEC=3. Each scenario task schedules expected (cycle, F, LED) entries in
// a queue as it drives stimulus, then steps the clock and compares each entry
// when its cycle comes up. Outputs are sampled 1 time unit after the rising
// edge; inputs are driven at the same point so the next edge samples them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_lamp_timer_ctrl;

  localparam int TICK_DIV = 10;
  localparam int DB_CYC   = 4;
  localparam int ON_SEC   = 3;

  localparam logic [6:0] L0 = 7'b1000000;
  localparam logic [6:0] L1 = 7'b1111001;
  localparam logic [6:0] L2 = 7'b0100100;
  localparam logic [6:0] L3 = 7'b0110000;

`ifdef LAMP_WARN_EN
  localparam logic WARN = 1'b1;
`else
  localparam logic WARN = 1'b0;
`endif
  // Expected F in the second half of the last second.
  localparam logic FW = WARN ? 1'b0 : 1'b1;

  logic       clk = 1'b0;
  logic       rst;
  logic       S1, S2, S3;
  logic [6:0] LED;
  logic       F;

  typedef struct {
    int unsigned at;
    logic        f;
    logic [6:0]  led;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  lamp_timer_ctrl #(
    .TICK_DIV(TICK_DIV),
    .DB_CYC  (DB_CYC),
    .ON_SEC  (ON_SEC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .S1 (S1),
    .S2 (S2),
    .S3 (S3),
    .LED(LED),
    .F  (F)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int unsigned at, input logic f, input logic [6:0] led);
    exp_t x;
    x.at  = at;
    x.f   = f;
    x.led = led;
    sb.push_back(x);
  endfunction

  task automatic test_reset();
    int unsigned c;
    rst = 1'b1; S1 = 1'b1; S2 = 1'b0; S3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push(cyc, 1'b0, L0);
    e = sb.pop_front();
    checks++;
    if (F !== e.f) begin errors++; $display("FAIL reset_F got %b want %b", F, e.f); end
    checks++;
    if (LED !== e.led) begin errors++; $display("FAIL reset_LED got %b want %b", LED, e.led); end
    rst = 1'b0;
    c = cyc;
    push(c + 1, 1'b0, L0);
    push(c + 5, 1'b0, L0);
    push(c + 10, 1'b0, L0);
    push(c + 20, 1'b0, L0);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (F !== e.f) begin errors++; $display("FAIL arm_F cyc %0d got %b want %b", cyc, F, e.f); end
        checks++;
        if (LED !== e.led) begin errors++; $display("FAIL arm_LED cyc %0d got %b want %b", cyc, LED, e.led); end
      end
    end
  endtask

  task automatic test_toggle();
    int unsigned c;
    c = cyc;
    S2 = 1'b1;
    push(c + 7,  1'b0, L0);
    push(c + 8,  1'b1, L3);
    push(c + 17, 1'b1, L3);
    push(c + 18, 1'b1, L2);
    push(c + 27, 1'b1, L2);
    push(c + 28, 1'b1, L1);
    push(c + 32, 1'b1, L1);
    push(c + 33, FW,   L1);
    push(c + 37, FW,   L1);
    push(c + 38, 1'b0, L0);
    push(c + 45, 1'b0, L0);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (F !== e.f) begin errors++; $display("FAIL toggle_F cyc %0d got %b want %b", cyc - c, F, e.f); end
        checks++;
        if (LED !== e.led) begin errors++; $display("FAIL toggle_LED cyc %0d got %b want %b", cyc - c, LED, e.led); end
      end
    end
  endtask

  task automatic test_glitch();
    int unsigned c;
    c = cyc;
    S3 = 1'b1;
    push(c + 5,  1'b0, L0);
    push(c + 10, 1'b0, L0);
    push(c + 15, 1'b0, L0);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      if (cyc == c + 3) S3 = 1'b0;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (F !== e.f) begin errors++; $display("FAIL glitch_F cyc %0d got %b want %b", cyc - c, F, e.f); end
        checks++;
        if (LED !== e.led) begin errors++; $display("FAIL glitch_LED cyc %0d got %b want %b", cyc - c, LED, e.led); end
      end
    end
  endtask

  task automatic test_retrigger();
    int unsigned c;
    c = cyc;
    S2 = 1'b0;
    // S1 event is timed to land on edge c+38, the final tick of this hold.
    push(c + 8,  1'b1, L3);
    push(c + 37, FW,   L1);
    push(c + 38, 1'b1, L3);
    push(c + 47, 1'b1, L3);
    push(c + 48, 1'b1, L2);
    push(c + 67, FW,   L1);
    push(c + 68, 1'b0, L0);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      if (cyc == c + 30) S1 = ~S1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (F !== e.f) begin errors++; $display("FAIL retrig_F cyc %0d got %b want %b", cyc - c, F, e.f); end
        checks++;
        if (LED !== e.led) begin errors++; $display("FAIL retrig_LED cyc %0d got %b want %b", cyc - c, LED, e.led); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned c;
    c = cyc;
    S1 = ~S1;
    S3 = ~S3;
    push(c + 7,  1'b0, L0);
    push(c + 8,  1'b1, L3);
    push(c + 32, 1'b1, L1);
    push(c + 37, FW,   L1);
    push(c + 38, 1'b0, L0);
    push(c + 48, 1'b0, L0);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (F !== e.f) begin errors++; $display("FAIL dual_F cyc %0d got %b want %b", cyc - c, F, e.f); end
        checks++;
        if (LED !== e.led) begin errors++; $display("FAIL dual_LED cyc %0d got %b want %b", cyc - c, LED, e.led); end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int unsigned c;
    c = cyc;
    S2 = ~S2;
    push(c + 8,  1'b1, L3);
    push(c + 19, 1'b1, L2);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (F !== e.f) begin errors++; $display("FAIL midhold_F cyc %0d got %b want %b", cyc - c, F, e.f); end
        checks++;
        if (LED !== e.led) begin errors++; $display("FAIL midhold_LED cyc %0d got %b want %b", cyc - c, LED, e.led); end
      end
    end
    // Pulse rst between clock edges: outputs must clear without an edge.
    #1 rst = 1'b1;
    #1;
    push(cyc, 1'b0, L0);
    e = sb.pop_front();
    checks++;
    if (F !== e.f) begin errors++; $display("FAIL async_rst_F got %b want %b", F, e.f); end
    checks++;
    if (LED !== e.led) begin errors++; $display("FAIL async_rst_LED got %b want %b", LED, e.led); end
    #2 rst = 1'b0;
    // Switch levels are unchanged, so re-arming must not create an event.
    c = cyc;
    push(c + 5,  1'b0, L0);
    push(c + 20, 1'b0, L0);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (F !== e.f) begin errors++; $display("FAIL rearm_F cyc %0d got %b want %b", cyc - c, F, e.f); end
        checks++;
        if (LED !== e.led) begin errors++; $display("FAIL rearm_LED cyc %0d got %b want %b", cyc - c, LED, e.led); end
      end
    end
    c = cyc;
    S2 = ~S2;
    push(c + 7,  1'b0, L0);
    push(c + 8,  1'b1, L3);
    push(c + 38, 1'b0, L0);
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (F !== e.f) begin errors++; $display("FAIL post_rst_F cyc %0d got %b want %b", cyc - c, F, e.f); end
        checks++;
        if (LED !== e.led) begin errors++; $display("FAIL post_rst_LED cyc %0d got %b want %b", cyc - c, LED, e.led); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_glitch();
    test_retrigger();
    test_back_to_back();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
